div_iter: RTL

//  Iterative radix-2 restoring divider. Services the EX-stage divide handshake:
//  EX holds start_i high and stalls the pipeline while ready_o=0, then drops start_i

---
 rtl/div_iter.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/div_iter.sv
`default_nettype none
// ============================================================================
// Module   : div_iter
// Purpose  : Iterative radix-2 restoring divider for the EX-stage DIV/DIVU
//            handshake. One quotient bit per clock, one divide in flight.
//            EX holds start_i until ready_o is seen, then drops it.
// Ports    : clk, rst           - clock, synchronous active-high reset
//            signed_div_i       - 1 = DIV (signed), 0 = DIVU; sampled at start
//            opdata1_i          - dividend, sampled at start
//            opdata2_i          - divisor, sampled at start
//            start_i            - divide request, held until ready_o
//            annul_i            - abort the current divide (pipeline flush)
//            result_o           - {remainder, quotient}, registered
//            ready_o            - result valid, registered
// Revision : 1.0 - initial release
// ============================================================================
module div_iter #(
  parameter int WD = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            signed_div_i,
  input  logic [WD-1:0]   opdata1_i,
  input  logic [WD-1:0]   opdata2_i,
  input  logic            start_i,
  input  logic            annul_i,
  output logic [2*WD-1:0] result_o,
  output logic            ready_o
);

  localparam int CW = $clog2(WD) + 1;
  localparam logic [CW-1:0] C_LAST_ITER = CW'(WD - 1);

  typedef enum logic [1:0] {
    S_FREE   = 2'd0,
    S_BYZERO = 2'd1,
    S_ON     = 2'd2,
    S_END    = 2'd3
  } state_t;

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [WD-1:0] r_dvd;        // dividend magnitude; quotient bits shift in at the bottom
  logic [WD-1:0] r_dvs;        // divisor magnitude
  logic [WD-1:0] r_rem;        // partial remainder
  logic          r_signed;
  logic          r_sign_op1;   // remainder takes the dividend's sign
  logic          r_sign_diff;  // quotient is negative when operand signs differ

  // Operand magnitudes at start. 0x80000000 negates to itself, which is the
  // correct unsigned magnitude, so no special case is needed.
  logic [WD-1:0] w_mag1;
  logic [WD-1:0] w_mag2;
  assign w_mag1 = (signed_div_i && opdata1_i[WD-1]) ? -opdata1_i : opdata1_i;
  assign w_mag2 = (signed_div_i && opdata2_i[WD-1]) ? -opdata2_i : opdata2_i;

  // One restoring step. The shifted remainder needs WD+1 bits; because the
  // remainder is always below the divisor, bit WD of the trial difference is
  // a reliable "went negative" flag.
  logic [WD:0]   w_rem_sh;
  logic [WD:0]   w_trial;
  logic          w_qbit;
  logic [WD-1:0] w_rem_nxt;
  logic [WD-1:0] w_quo_nxt;
  logic [WD-1:0] w_quo_fix;
  logic [WD-1:0] w_rem_fix;
  logic          w_last;

  assign w_rem_sh  = {r_rem, r_dvd[WD-1]};
  assign w_trial   = w_rem_sh - {1'b0, r_dvs};
  assign w_qbit    = ~w_trial[WD];
  assign w_rem_nxt = w_qbit ? w_trial[WD-1:0] : w_rem_sh[WD-1:0];
  assign w_quo_nxt = {r_dvd[WD-2:0], w_qbit};
  assign w_last    = (r_cnt == C_LAST_ITER);

  // Sign fixup, only consumed on the final iteration.
  assign w_quo_fix = (r_signed && r_sign_diff) ? -w_quo_nxt : w_quo_nxt;
  assign w_rem_fix = (r_signed && r_sign_op1)  ? -w_rem_nxt : w_rem_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_FREE;
      r_cnt       <= '0;
      r_dvd       <= '0;
      r_dvs       <= '0;
      r_rem       <= '0;
      r_signed    <= 1'b0;
      r_sign_op1  <= 1'b0;
      r_sign_diff <= 1'b0;
      result_o    <= '0;
      ready_o     <= 1'b0;
    end else begin
      case (r_state)
        S_FREE: begin
          ready_o  <= 1'b0;
          result_o <= '0;
          if (start_i && !annul_i) begin
            r_cnt <= '0;
            r_rem <= '0;
            if (opdata2_i == '0) begin
              r_state <= S_BYZERO;
            end else begin
              r_state     <= S_ON;
              r_dvd       <= w_mag1;
              r_dvs       <= w_mag2;
              r_signed    <= signed_div_i;
              r_sign_op1  <= opdata1_i[WD-1];
              r_sign_diff <= opdata1_i[WD-1] ^ opdata2_i[WD-1];
            end
          end
        end

        S_BYZERO: begin
          if (annul_i) begin
            r_state <= S_FREE;
          end else begin
            r_state  <= S_END;
            result_o <= '0;
            ready_o  <= 1'b1;
          end
        end

        S_ON: begin
          // start_i is deliberately ignored here; only a flush stops the divide.
          if (annul_i) begin
            r_state  <= S_FREE;
            ready_o  <= 1'b0;
            result_o <= '0;
          end else begin
            r_rem <= w_rem_nxt;
            r_dvd <= w_quo_nxt;
            r_cnt <= r_cnt + 1'b1;
            if (w_last) begin
              r_state  <= S_END;
              result_o <= {w_rem_fix, w_quo_fix};
              ready_o  <= 1'b1;
            end
          end
        end

        S_END: begin
          // Hold the result while EX still asserts start_i.
          if (annul_i || !start_i) begin
            r_state  <= S_FREE;
            ready_o  <= 1'b0;
            result_o <= '0;
          end else begin
            ready_o  <= 1'b1;
          end
        end

        default: begin
          r_state  <= S_FREE;
          ready_o  <= 1'b0;
          result_o <= '0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
